// File: rtl/brq_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package brq_pkg;

    typedef enum logic [1:0] {
        ARB_BOOT,
        ARB_RUN,
        ARB_LSU_DATA
    } arb_state_e;

    localparam int unsigned RESET_PC = 0;

endpackage

// File: rtl/imem_boot_writer.sv
// Boot-time write pointer (wraps at memory depth) and saturating loaded-word counter.
import brq_pkg::*;

module imem_boot_writer #(
    parameter int AddrWidth = 15
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst_n,
    input  logic                 i_wr_en,
    output logic [AddrWidth-1:0] o_wr_ptr,
    output logic [AddrWidth:0]   o_word_count
);

    localparam logic [AddrWidth:0] COUNT_FULL = {1'b1, {AddrWidth{1'b0}}};

    logic [AddrWidth-1:0] r_ptr;
    logic [AddrWidth:0]   r_count;

    always_ff @(posedge brq_clk) begin
        if (!brq_rst_n) begin
            r_ptr   <= AddrWidth'(RESET_PC);
            r_count <= '0;
        end else if (i_wr_en) begin
            r_ptr <= r_ptr + AddrWidth'(1);
            if (r_count != COUNT_FULL) begin
                r_count <= r_count + (AddrWidth + 1)'(1);
            end
        end
    end

    assign o_wr_ptr     = r_ptr;
    assign o_word_count = r_count;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between boot loader, IFU and LSU,
// and holds the IFU in stall whenever the previous memory slot was not its own.
//
// state        | meaning
// ARB_BOOT     | loader owns the memory, IFU stalled, LSU held off
// ARB_RUN      | IFU fetches; LSU may take the slot
// ARB_LSU_DATA | LSU read data returning; arbitration continues
import brq_pkg::*;

module imem_arbiter #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 15,
    parameter int MaxLsuBurst = 4
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst_n,
    input  logic                 ld_valid,
    input  logic [DataWidth-1:0] ld_data,
    input  logic                 ld_done,
    output logic                 ld_ready,
    input  logic [AddrWidth-1:0] ifu_addr,
    output logic [DataWidth-1:0] ifu_data,
    output logic                 arb_ifu_stall,
    input  logic                 lsu_req,
    input  logic [AddrWidth-1:0] lsu_addr,
    output logic                 lsu_gnt,
    output logic                 lsu_rvalid,
    output logic [DataWidth-1:0] lsu_rdata,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 boot_active,
    output logic [AddrWidth:0]   ld_word_count
);

    localparam int BW = $clog2(MaxLsuBurst + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MaxLsuBurst);

    arb_state_e           r_state;
    arb_state_e           w_next;
    logic [BW-1:0]        r_burst;
    logic                 r_first_run;
    logic                 w_gnt;
    logic                 w_wr_en;
    logic [AddrWidth-1:0] w_wr_ptr;

    assign w_wr_en = brq_rst_n && (r_state == ARB_BOOT) && ld_valid;
    assign w_gnt   = brq_rst_n && (r_state != ARB_BOOT) && lsu_req && (r_burst < BURST_MAX);

    imem_boot_writer #(
        .AddrWidth(AddrWidth)
    ) u_boot_writer (
        .brq_clk     (brq_clk),
        .brq_rst_n   (brq_rst_n),
        .i_wr_en     (w_wr_en),
        .o_wr_ptr    (w_wr_ptr),
        .o_word_count(ld_word_count)
    );

    always_ff @(posedge brq_clk) begin
        if (!brq_rst_n) begin
            r_state     <= ARB_BOOT;
            r_burst     <= '0;
            r_first_run <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_first_run <= (r_state == ARB_BOOT) && ld_done;
            if (r_state != ARB_BOOT) begin
                r_burst <= w_gnt ? r_burst + BW'(1) : '0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_BOOT:               if (ld_done) w_next = ARB_RUN;
            ARB_RUN, ARB_LSU_DATA:  w_next = w_gnt ? ARB_LSU_DATA : ARB_RUN;
            default:                w_next = ARB_BOOT;
        endcase
    end

    // The first RUN cycle is stalled so the fetch at the reset PC has time to return.
    always_comb begin
        ld_ready      = 1'b0;
        boot_active   = 1'b0;
        arb_ifu_stall = 1'b1;
        lsu_gnt       = 1'b0;
        lsu_rvalid    = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = ifu_addr;
        case (r_state)
            ARB_BOOT: begin
                ld_ready    = brq_rst_n;
                boot_active = 1'b1;
                mem_we      = w_wr_en;
                mem_addr    = w_wr_ptr;
            end
            ARB_RUN: begin
                lsu_gnt       = w_gnt;
                arb_ifu_stall = w_gnt || r_first_run;
                if (w_gnt) mem_addr = lsu_addr;
            end
            ARB_LSU_DATA: begin
                lsu_rvalid = brq_rst_n;
                lsu_gnt    = w_gnt;
                if (w_gnt) mem_addr = lsu_addr;
            end
            default: begin
                arb_ifu_stall = 1'b1;
            end
        endcase
        if (!brq_rst_n) arb_ifu_stall = 1'b1;
    end

    assign mem_wdata = ld_data;
    assign ifu_data  = mem_rdata;
    assign lsu_rdata = mem_rdata;

endmodule
